// File: rtl/exc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_redirect_ctrl
// Function : Front-end redirect sequencer for exception commit and ERET. It
//            flushes, drains stale instruction responses, then hands the
//            target to fetch. Optional counters: EXC_REDIRECT_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module exc_redirect_ctrl #(
    parameter logic [31:0] EXC_VEC = 32'hBFC0_0380,
    parameter int          OUTST_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_oc,
    input  logic        eret,
    input  logic [31:0] cp0_epc,
    input  logic        inst_req_fire,
    input  logic        inst_data_ok,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        fetch_stall,
    output logic        discard_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_drain_cyc
);

    localparam logic [OUTST_W-1:0] c_outst_max = {OUTST_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OUTST_W-1:0] r_outst;
    logic [OUTST_W-1:0] w_outst_nxt;
    logic               w_load_pc;
    logic [31:0]        w_pc_nxt;

    // Outstanding request tracking: saturates at both ends so a protocol
    // error on data_ok cannot wrap the count.
    always_comb begin
        w_outst_nxt = r_outst;
        if (inst_req_fire && inst_data_ok) begin
            w_outst_nxt = r_outst;
        end else if (inst_req_fire && (r_outst != c_outst_max)) begin
            w_outst_nxt = r_outst + 1'b1;
        end else if (inst_data_ok && (r_outst != '0)) begin
            w_outst_nxt = r_outst - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_outst     <= '0;
            redirect_pc <= EXC_VEC;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= w_outst_nxt;
            if (w_load_pc) begin
                redirect_pc <= w_pc_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        flush          = 1'b0;
        fetch_stall    = 1'b1;
        discard_rdata  = 1'b0;
        redirect_valid = 1'b0;
        w_load_pc      = 1'b0;
        w_pc_nxt       = EXC_VEC;

        case (r_state)
            ST_IDLE: begin
                fetch_stall = (r_outst == c_outst_max);
                if (exc_oc || eret) begin
                    flush       = 1'b1;
                    w_load_pc   = 1'b1;
                    w_pc_nxt    = exc_oc ? EXC_VEC : cp0_epc;
                    w_state_nxt = (w_outst_nxt == '0) ? ST_REDIRECT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                discard_rdata = inst_data_ok;
                if (w_outst_nxt == '0) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // A late exception cancels the offer so fetch never takes a stale target.
                redirect_valid = !exc_oc;
                if (redirect_ready && !exc_oc) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Late interrupt: restart the sequence toward the exception vector.
        if ((r_state != ST_IDLE) && exc_oc) begin
            flush       = 1'b1;
            w_load_pc   = 1'b1;
            w_pc_nxt    = EXC_VEC;
            w_state_nxt = (w_outst_nxt == '0) ? ST_REDIRECT : ST_DRAIN;
        end
    end

`ifdef EXC_REDIRECT_PERF_EN
    logic [31:0] r_perf_flush_cnt;
    logic [31:0] r_perf_drain_cyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_flush_cnt <= '0;
            r_perf_drain_cyc <= '0;
        end else begin
            if (flush) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
            if (r_state == ST_DRAIN) begin
                r_perf_drain_cyc <= r_perf_drain_cyc + 32'd1;
            end
        end
    end

    assign perf_flush_cnt = r_perf_flush_cnt;
    assign perf_drain_cyc = r_perf_drain_cyc;
`else
    assign perf_flush_cnt = '0;
    assign perf_drain_cyc = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_redirect_ctrl
// Function : Directed and randomized bench for exc_redirect_ctrl against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_redirect_ctrl;

    localparam logic [31:0] c_exc_vec   = 32'hBFC0_0380;
    localparam int          c_outst_w   = 3;
    localparam int          c_outst_max = (1 << c_outst_w) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exc_oc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        inst_req_fire = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        flush;
    logic        fetch_stall;
    logic        discard_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_drain_cyc;

    exc_redirect_ctrl #(
        .EXC_VEC (c_exc_vec),
        .OUTST_W (c_outst_w)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .exc_oc         (exc_oc),
        .eret           (eret),
        .cp0_epc        (cp0_epc),
        .inst_req_fire  (inst_req_fire),
        .inst_data_ok   (inst_data_ok),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .fetch_stall    (fetch_stall),
        .discard_rdata  (discard_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_drain_cyc (perf_drain_cyc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a redirect is "pending" from the flush until fetch accepts
    // it; it is "drained" once no stale responses remain in flight.
    int          m_outst = 0;
    bit          m_pend = 1'b0;
    bit          m_drained = 1'b0;
    logic [31:0] m_target = c_exc_vec;
    logic [31:0] m_flushes = '0;
    logic [31:0] m_drain_cyc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        return m_pend || (m_outst == c_outst_max);
    endfunction

    task automatic step(input bit rst, input bit f, input bit dok, input bit exc,
                        input bit er, input logic [31:0] epc, input bit rdy);
        bit e_flush, e_valid, e_stall, e_disc;
        int n;
        @(posedge clk);
        #1;
        reset          = rst;
        inst_req_fire  = f;
        inst_data_ok   = dok;
        exc_oc         = exc;
        eret           = er;
        cp0_epc        = epc;
        redirect_ready = rdy;
        @(negedge clk);
        if (rst) begin
            m_outst = 0; m_pend = 0; m_drained = 0;
            m_target = c_exc_vec; m_flushes = '0; m_drain_cyc = '0;
            return;
        end
        e_flush = exc || (er && !m_pend);
        e_valid = m_pend && m_drained && !exc;
        e_stall = model_stall();
        e_disc  = m_pend && !m_drained && dok;
        chk("flush", {31'b0, flush}, {31'b0, e_flush});
        chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, e_stall});
        chk("discard_rdata", {31'b0, discard_rdata}, {31'b0, e_disc});
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e_valid});
        chk("redirect_pc", redirect_pc, m_target);
`ifdef EXC_REDIRECT_PERF_EN
        chk("perf_flush_cnt", perf_flush_cnt, m_flushes);
        chk("perf_drain_cyc", perf_drain_cyc, m_drain_cyc);
`else
        chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
        chk("perf_drain_cyc", perf_drain_cyc, 32'd0);
`endif
        n = m_outst;
        if (f && dok) n = m_outst;
        else if (f) n = (m_outst == c_outst_max) ? m_outst : m_outst + 1;
        else if (dok) n = (m_outst == 0) ? 0 : m_outst - 1;
        if (m_pend && !m_drained) m_drain_cyc = m_drain_cyc + 32'd1;
        if (e_flush) begin
            m_flushes = m_flushes + 32'd1;
            m_pend    = 1'b1;
            m_target  = exc ? c_exc_vec : epc;
            m_drained = (n == 0);
        end else if (m_pend && m_drained && rdy) begin
            m_pend = 1'b0;
        end else if (m_pend && !m_drained && n == 0) begin
            m_drained = 1'b1;
        end
        m_outst = n;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        idle(2);

        // Exception with nothing outstanding, accepted immediately.
        step(0, 0, 0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        idle(2);

        // ERET with two responses in flight.
        step(0, 1, 0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h8000_1234, 0);
        step(0, 0, 1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        idle(1);

        // Simultaneous exception and ERET, then a late interrupt in REDIRECT.
        step(0, 0, 0, 1, 1, 32'h1234_5678, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'h0, 1);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        idle(1);

        // Counter saturation in IDLE.
        for (int i = 0; i < c_outst_max; i++) step(0, 1, 0, 0, 0, 32'h0, 0);
        step(0, 0, 1, 0, 0, 32'h0, 0);
        idle(1);
        for (int i = 0; i < c_outst_max - 1; i++) step(0, 0, 1, 0, 0, 32'h0, 0);
        idle(1);

        // Reset while draining three stale responses.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            bit r_rst, r_f, r_dok, r_exc, r_er, r_rdy;
            r_rst = ($urandom_range(0, 299) == 0);
            r_f   = !model_stall() && ($urandom_range(0, 1) == 1);
            r_dok = (m_outst > 0) && ($urandom_range(0, 9) < 4);
            r_exc = ($urandom_range(0, 19) == 0);
            r_er  = ($urandom_range(0, 19) == 0);
            r_rdy = ($urandom_range(0, 1) == 1);
            step(r_rst, r_f, r_dok, r_exc, r_er, $urandom, r_rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
